mdio_responder: RTL and testbench

MDIO_RESPONDER -- requirements
Module: mdio_responder

---
 rtl/mdio_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause 22 MDIO management responder with a small register file, clocked entirely on clk.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept a start of frame without the 32-bit preamble.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR   = 5'd1,
    parameter logic [15:0] STATUS_VAL = 16'h796D,
    parameter logic [15:0] PHY_ID1    = 16'h0022,
    parameter logic [15:0] PHY_ID2    = 16'h1622
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdio_mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        soft_rst,
    output logic        frame_err
);
    typedef enum logic [3:0] {
        StIdle, StSt, StOp, StPhyad, StRegad, StTa, StWdata, StRdata, StSkip
    } state_e;

    logic [2:0]  mdc_sync_q;
    logic [1:0]  mdi_sync_q;
    logic        rise, fall, bit_in, pre_ok;
    state_e      state_q, state_d;
    logic [4:0]  fidx_q, fidx_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic        is_read_q, is_read_d, phy_match_q, phy_match_d, ta1_q, ta1_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic        drive_q, drive_d, out_q, out_d;
    logic        commit, err_d, soft_clr;
    logic [4:0]  field5;
    logic [1:0]  op_bits;
    logic [15:0] commit_data, rd_mux;
    logic [14:0] reg0_q;
    logic [15:0] regs_q [4:31];
    logic        wr_strobe_q, soft_rst_q, frame_err_q;
    logic [4:0]  wr_addr_q;
    logic [15:0] wr_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_sync_q <= 3'b000;
            mdi_sync_q <= 2'b11;
        end else begin
            mdc_sync_q <= {mdc_sync_q[1:0], mdio_mdc};
            mdi_sync_q <= {mdi_sync_q[0], mdio_in};
        end
    end

    assign rise        = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign fall        = ~mdc_sync_q[1] & mdc_sync_q[2];
    assign bit_in      = mdi_sync_q[1];
    assign field5      = {shreg_q[3:0], bit_in};
    assign op_bits     = {shreg_q[0], bit_in};
    assign commit_data = {shreg_q[14:0], bit_in};
    assign soft_clr    = commit && (reg_addr_q == 5'd0) && commit_data[15];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign pre_ok = 1'b1;
`else
    assign pre_ok = (pre_cnt_q == 6'd32);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state; fidx_q is the frame bit index (ST=0..DATA=31) of the bit being sampled.
    always_comb begin
        state_d = state_q;
        if (rise) begin
            unique case (state_q)
                StIdle:  if (!bit_in && pre_ok) state_d = StSt;
                StSt:    state_d = bit_in ? StOp : StIdle;
                StOp:    if (fidx_q == 5'd3)
                             state_d = (op_bits == 2'b10 || op_bits == 2'b01) ? StPhyad : StSkip;
                StPhyad: if (fidx_q == 5'd8) state_d = StRegad;
                StRegad: if (fidx_q == 5'd13) state_d = phy_match_q ? StTa : StSkip;
                StTa:    if (fidx_q == 5'd15)
                             state_d = is_read_q ? StRdata :
                                       (ta1_q && !bit_in) ? StWdata : StSkip;
                StWdata, StRdata, StSkip: if (fidx_q == 5'd31) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath and pad control.
    always_comb begin
        fidx_d      = fidx_q;
        pre_cnt_d   = pre_cnt_q;
        shreg_d     = shreg_q;
        is_read_d   = is_read_q;
        phy_match_d = phy_match_q;
        reg_addr_d  = reg_addr_q;
        ta1_d       = ta1_q;
        drive_d     = drive_q;
        out_d       = out_q;
        commit      = 1'b0;
        err_d       = 1'b0;
        if (rise) begin
            fidx_d = fidx_q + 5'd1;
            unique case (state_q)
                StIdle: begin
                    fidx_d = 5'd1;
                    if (bit_in) pre_cnt_d = (pre_cnt_q == 6'd32) ? pre_cnt_q : pre_cnt_q + 6'd1;
                    else        pre_cnt_d = 6'd0;
                end
                StOp: begin
                    shreg_d   = commit_data;
                    is_read_d = (op_bits == 2'b10);
                end
                StPhyad: begin
                    shreg_d     = commit_data;
                    phy_match_d = (field5 == PHY_ADDR);
                end
                StRegad: begin
                    shreg_d = commit_data;
                    if (fidx_q == 5'd13) begin
                        reg_addr_d = field5;
                        shreg_d    = rd_mux;
                    end
                end
                StTa: begin
                    if (fidx_q == 5'd14) ta1_d = bit_in;
                    if (fidx_q == 5'd15 && !is_read_q && !(ta1_q && !bit_in)) err_d = 1'b1;
                end
                StWdata: begin
                    shreg_d = commit_data;
                    if (fidx_q == 5'd31) commit = 1'b1;
                end
                default: ;
            endcase
        end
        if (fall) begin
            drive_d = 1'b0;
            out_d   = 1'b1;
            if (state_q == StTa && is_read_q && fidx_q == 5'd15) begin
                drive_d = 1'b1;
                out_d   = 1'b0;
            end else if (state_q == StRdata) begin
                drive_d = 1'b1;
                out_d   = shreg_q[15];
                shreg_d = {shreg_q[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fidx_q      <= 5'd0;
            pre_cnt_q   <= 6'd0;
            shreg_q     <= 16'd0;
            is_read_q   <= 1'b0;
            phy_match_q <= 1'b0;
            reg_addr_q  <= 5'd0;
            ta1_q       <= 1'b0;
            drive_q     <= 1'b0;
            out_q       <= 1'b1;
        end else begin
            fidx_q      <= fidx_d;
            pre_cnt_q   <= (state_d == StIdle) ? pre_cnt_d : 6'd0;
            shreg_q     <= shreg_d;
            is_read_q   <= is_read_d;
            phy_match_q <= phy_match_d;
            reg_addr_q  <= reg_addr_d;
            ta1_q       <= ta1_d;
            drive_q     <= drive_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        case (field5)
            5'd0:    rd_mux = {1'b0, reg0_q};
            5'd1:    rd_mux = STATUS_VAL;
            5'd2:    rd_mux = PHY_ID1;
            5'd3:    rd_mux = PHY_ID2;
            default: rd_mux = regs_q[field5];
        endcase
    end

    // Regs 1-3 are constants; a reg0 write with bit15 set restores every RW register.
    always_ff @(posedge clk) begin
        if (rst || soft_clr) begin
            reg0_q <= 15'h1140;
            for (int i = 4; i < 32; i++) regs_q[i] <= 16'd0;
        end else if (commit) begin
            if (reg_addr_q == 5'd0)       reg0_q <= commit_data[14:0];
            else if (reg_addr_q >= 5'd4)  regs_q[reg_addr_q] <= commit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_strobe_q <= 1'b0;
            soft_rst_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 16'd0;
        end else begin
            wr_strobe_q <= commit;
            soft_rst_q  <= soft_clr;
            frame_err_q <= err_d;
            if (commit) begin
                wr_addr_q <= reg_addr_q;
                wr_data_q <= commit_data;
            end
        end
    end

    assign mdio_oen  = ~drive_q;
    assign mdio_out  = out_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign soft_rst  = soft_rst_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_mdio_responder.sv
// Randomised scoreboard bench for mdio_responder: a MAC-side bit driver issues frames and pushes
// expectations from a register-level model; a monitor pops them against DUT reads, writes, errors.
module tb_mdio_responder;
    localparam logic [4:0] PHY = 5'd1;

    logic        clk = 1'b0;
    logic        rst, mdc, mac_val, pad;
    logic        mdio_out, mdio_oen, wr_strobe, soft_rst, frame_err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int total = 0;
    int bad   = 0;

    logic [16:0] rd_q [$];
    logic [21:0] wr_q [$];
    bit          err_q [$];
    logic [15:0] m_regs [32];

    always #5 clk = ~clk;

    // Open-drain bus: the MAC's value (1 = released, pulled up) unless the DUT drives.
    assign pad = mdio_oen ? mac_val : mdio_out;

    mdio_responder dut (
        .clk       (clk),
        .rst       (rst),
        .mdio_mdc  (mdc),
        .mdio_in   (pad),
        .mdio_out  (mdio_out),
        .mdio_oen  (mdio_oen),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .soft_rst  (soft_rst),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        m_regs[0] = 16'h1140;
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        case (a)
            5'd1:    return 16'h796D;
            5'd2:    return 16'h0022;
            5'd3:    return 16'h1622;
            default: return m_regs[a];
        endcase
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0 && d[15]) model_reset();
        else if (a == 5'd0)     m_regs[0] = d & 16'h7FFF;
        else if (a >= 5'd4)     m_regs[a] = d;
    endtask

    // One MDC cycle of 8 clks: MAC changes data with the falling edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        mac_val = b;
        mdc     = 1'b0;
        repeat (3) @(negedge clk);
        mdc = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d,
                         input int abort_at);
        logic [31:0] f;
        if (op == 2'b10) f = {2'b01, op, phy, ra, 2'b11, 16'hFFFF};
        else             f = {2'b01, op, phy, ra, ta, d};
        for (int i = 0; i < pre; i++) send_bit(1'b1);
        for (int k = 0; k < 32; k++) begin
            if (k == abort_at) begin
                @(negedge clk);
                rst     = 1'b1;
                mdc     = 1'b0;
                mac_val = 1'b1;
                @(posedge clk);
                #1;
                check("oen_after_rst", {31'd0, mdio_oen}, 32'd1);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                model_reset();
                return;
            end
            send_bit(f[31-k]);
        end
        @(negedge clk);
        mdc = 1'b0;
    endtask

    // Push what the responder must do with this frame, then issue it.
    task automatic xfer(input int pre, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d);
        bit responds;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        responds = (phy == PHY);
`else
        responds = (phy == PHY) && (pre >= 32);
`endif
        if (responds && op == 2'b10) begin
            rd_q.push_back({1'b0, model_read(ra)});
        end else if (responds && op == 2'b01) begin
            if (ta == 2'b10) begin
                wr_q.push_back({(ra == 5'd0) && d[15], ra, d});
                model_write(ra, d);
            end else begin
                err_q.push_back(1'b1);
            end
        end
        frame(pre, op, phy, ra, ta, d, -1);
    endtask

    // Monitor: collects bits the DUT drives at MDC rising edges and watches the strobes.
    int          rd_cnt = 0;
    logic [16:0] rd_bits = '0;
    logic        mdc_prev = 1'b0;
    logic [16:0] rd_exp;
    logic [21:0] wr_exp;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            rd_cnt  = 0;
            rd_bits = '0;
        end else begin
            if (mdc && !mdc_prev && !mdio_oen) begin
                rd_bits = {rd_bits[15:0], mdio_out};
                rd_cnt++;
                if (rd_cnt == 17) begin
                    if (rd_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL read_unexpected: got %0h expected no response", rd_bits);
                    end else begin
                        rd_exp = rd_q.pop_front();
                        check("read_data", {15'd0, rd_bits}, {15'd0, rd_exp});
                    end
                    rd_cnt = 0;
                end
            end
            if (wr_strobe) begin
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL write_unexpected: got addr %0h data %0h expected none",
                             wr_addr, wr_data);
                end else begin
                    wr_exp = wr_q.pop_front();
                    check("wr_addr", {27'd0, wr_addr}, {27'd0, wr_exp[20:16]});
                    check("wr_data", {16'd0, wr_data}, {16'd0, wr_exp[15:0]});
                    check("soft_rst", {31'd0, soft_rst}, {31'd0, wr_exp[21]});
                end
            end else if (soft_rst) begin
                total++; bad++;
                $display("FAIL soft_rst_alone: got 1 expected 0");
            end
            if (frame_err) begin
                total++;
                if (err_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_err_unexpected: got 1 expected 0");
                end else begin
                    void'(err_q.pop_front());
                end
            end
            if (mdio_oen && mdio_out !== 1'b1) begin
                total++; bad++;
                $display("FAIL out_when_released: got %b expected 1", mdio_out);
            end
        end
        mdc_prev = mdc;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  bad_tas [3];
        int          kind;
        logic [4:0]  phy, ra;
        logic [15:0] d;
        bad_tas = '{2'b00, 2'b01, 2'b11};
        rst     = 1'b1;
        mdc     = 1'b0;
        mac_val = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_oen", {31'd0, mdio_oen}, 32'd1);
        check("rst_out", {31'd0, mdio_out}, 32'd1);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_soft_rst", {31'd0, soft_rst}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        xfer(32, 2'b01, PHY, 5'd4, 2'b10, 16'hA5C3);
        xfer(32, 2'b10, PHY, 5'd4, 2'b11, 16'h0000);
        xfer(32, 2'b10, 5'd2, 5'd4, 2'b11, 16'h0000);
        xfer(32, 2'b01, PHY, 5'd4, 2'b10, 16'h1234);
        xfer(32, 2'b01, PHY, 5'd0, 2'b10, 16'h8000);
        xfer(32, 2'b10, PHY, 5'd4, 2'b11, 16'h0000);
        xfer(32, 2'b10, PHY, 5'd0, 2'b11, 16'h0000);
        xfer(32, 2'b01, PHY, 5'd5, 2'b11, 16'hBEEF);
        xfer(32, 2'b10, PHY, 5'd5, 2'b11, 16'h0000);
        xfer(20, 2'b10, PHY, 5'd2, 2'b11, 16'h0000);
        xfer(32, 2'b01, PHY, 5'd4, 2'b10, 16'h5A5A);
        xfer(32, 2'b01, PHY, 5'd2, 2'b10, 16'hFFFF);
        xfer(32, 2'b10, PHY, 5'd2, 2'b11, 16'h0000);
        frame(32, 2'b10, PHY, 5'd4, 2'b11, 16'h0000, 23);
        xfer(32, 2'b10, PHY, 5'd0, 2'b11, 16'h0000);
        xfer(32, 2'b10, PHY, 5'd4, 2'b11, 16'h0000);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            phy  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(2, 31)) : PHY;
            ra   = 5'($urandom_range(0, 31));
            d    = 16'($urandom);
            if (kind < 4)       xfer(32, 2'b10, phy, ra, 2'b11, d);
            else if (kind < 8)  xfer(32, 2'b01, phy, ra, 2'b10, d);
            else if (kind == 8) xfer(32, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11,
                                     phy, ra, 2'b10, d);
            else                xfer(32, 2'b01, phy, ra, bad_tas[$urandom_range(0, 2)], d);
        end
        for (int a = 0; a < 6; a++) xfer(32, 2'b10, PHY, 5'(a), 2'b11, 16'h0000);

        repeat (40) @(negedge clk);
        check("read_pending", rd_q.size(), 32'd0);
        check("write_pending", wr_q.size(), 32'd0);
        check("frame_err_pending", err_q.size(), 32'd0);
        check("read_partial", rd_cnt, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
